// File: rtl/wb_bus_watchdog.sv
// Wishbone bus-timeout guard: forwards classic cycles between the CPU and the intercon with zero latency.
// A transfer left unterminated for TIMEOUT clocks is aborted, and the fault address, direction and count are recorded.
module wb_bus_watchdog #(
    parameter int             AW           = 32,
    parameter int             DW           = 32,
    parameter int             TIMEOUT      = 1024,
    parameter logic [DW-1:0]  TIMEOUT_DATA = DW'(32'hDEAD_BEEF)
) (
    input  logic              wb_clk,
    input  logic              wb_rst,
    input  logic [AW-1:0]     wbs_adr_i,
    input  logic [DW-1:0]     wbs_dat_i,
    input  logic [DW/8-1:0]   wbs_sel_i,
    input  logic              wbs_we_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    output logic [DW-1:0]     wbs_dat_o,
    output logic              wbs_ack_o,
    output logic              wbs_err_o,
    output logic [AW-1:0]     wbm_adr_o,
    output logic [DW-1:0]     wbm_dat_o,
    output logic [DW/8-1:0]   wbm_sel_o,
    output logic              wbm_we_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    input  logic [DW-1:0]     wbm_dat_i,
    input  logic              wbm_ack_i,
    input  logic              wbm_err_i,
    output logic              timeout_o,
    output logic [AW-1:0]     fault_adr_o,
    output logic              fault_we_o,
    output logic [7:0]        fault_cnt_o,
    input  logic              fault_clr_i
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, ABORT, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [AW-1:0]   fault_adr_q, fault_adr_d;
    logic            fault_we_q, fault_we_d;
    logic [7:0]      fault_cnt_q, fault_cnt_d;
    logic            req, abort;

    assign wbm_adr_o   = wbs_adr_i;
    assign wbm_dat_o   = wbs_dat_i;
    assign wbm_sel_o   = wbs_sel_i;
    assign wbm_we_o    = wbs_we_i;
    assign fault_adr_o = fault_adr_q;
    assign fault_we_o  = fault_we_q;
    assign fault_cnt_o = fault_cnt_q;

    assign req     = wbs_cyc_i & wbs_stb_i;
    assign cnt_inc = cnt_q + CW'(1);
    assign abort   = (state_q == ABORT);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wbm_cyc_o = 1'b0;
        wbm_stb_o = 1'b0;
        wbs_ack_o = 1'b0;
        wbs_err_o = 1'b0;
        wbs_dat_o = wbm_dat_i;
        timeout_o = 1'b0;
        case (state_q)
            IDLE, WAIT: begin
                wbm_cyc_o = wbs_cyc_i;
                wbm_stb_o = wbs_stb_i;
                wbs_ack_o = wbm_ack_i;
                wbs_err_o = wbm_err_i;
                if (req && !(wbm_ack_i || wbm_err_i)) begin
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == CW'(TIMEOUT)) ? ABORT : WAIT;
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            // picorv32_wb has no err input, so ack accompanies err to release the CPU.
            ABORT: begin
                wbs_ack_o = 1'b1;
                wbs_err_o = 1'b1;
                wbs_dat_o = TIMEOUT_DATA;
                timeout_o = 1'b1;
                cnt_d     = '0;
                state_d   = DRAIN;
            end
            DRAIN: begin
                if (!wbs_stb_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fault_adr_d = fault_adr_q;
        fault_we_d  = fault_we_q;
        fault_cnt_d = fault_cnt_q;
        if (abort) begin
            fault_adr_d = wbs_adr_i;
            fault_we_d  = wbs_we_i;
        end
        // A clear coinciding with an abort still counts that abort.
        if (fault_clr_i) begin
            fault_cnt_d = abort ? 8'd1 : 8'd0;
        end else if (abort && fault_cnt_q != 8'hFF) begin
            fault_cnt_d = fault_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            fault_adr_q <= '0;
            fault_we_q  <= 1'b0;
            fault_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fault_adr_q <= fault_adr_d;
            fault_we_q  <= fault_we_d;
            fault_cnt_q <= fault_cnt_d;
        end
    end
endmodule

// File: tb/tb_wb_bus_watchdog.sv
// Bench for wb_bus_watchdog: directed transfers against a pending-age model checked every cycle,
// plus literal expectations for completion cycle, abort data and fault registers.
module tb_wb_bus_watchdog;
    localparam int TO = 16;
    localparam logic [31:0] POISON = 32'hDEAD_BEEF;

    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b1;
    logic [31:0] adr = '0, dat_w = '0, s_dat = '0;
    logic [3:0]  sel = 4'hF;
    logic        we = 1'b0, cyc = 1'b0, stb = 1'b0, s_ack = 1'b0, s_err = 1'b0, clr = 1'b0;

    logic [31:0] wbs_dat_o, wbm_adr_o, wbm_dat_o, fault_adr_o;
    logic [3:0]  wbm_sel_o;
    logic        wbs_ack_o, wbs_err_o, wbm_we_o, wbm_cyc_o, wbm_stb_o, timeout_o, fault_we_o;
    logic [7:0]  fault_cnt_o;

    int checks = 0;
    int errors = 0;

    wb_bus_watchdog #(.AW(32), .DW(32), .TIMEOUT(TO), .TIMEOUT_DATA(POISON)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_sel_i(sel), .wbs_we_i(we),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_dat_i(s_dat), .wbm_ack_i(s_ack), .wbm_err_i(s_err),
        .timeout_o(timeout_o), .fault_adr_o(fault_adr_o), .fault_we_o(fault_we_o),
        .fault_cnt_o(fault_cnt_o), .fault_clr_i(clr)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 50) $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: age = cycles the current request has been pending; aborted requests drain until stb drops.
    int          m_age = 0;
    bit          m_drain = 0;
    int          m_fcnt = 0;
    logic [31:0] m_fadr = '0;
    logic        m_fwe = 1'b0;

    function automatic bit m_aborting();
        return !m_drain && (m_age == TO);
    endfunction

    task automatic m_reset();
        m_age = 0; m_drain = 0; m_fcnt = 0; m_fadr = '0; m_fwe = 1'b0;
    endtask

    always @(posedge wb_clk) begin
        if (wb_rst) m_reset();
        else begin
            if (m_aborting()) begin
                m_fadr  = adr;
                m_fwe   = we;
                m_fcnt  = clr ? 1 : ((m_fcnt + 1 > 255) ? 255 : m_fcnt + 1);
                m_age   = 0;
                m_drain = 1;
            end else begin
                if (clr) m_fcnt = 0;
                if (m_drain) begin
                    if (!stb) m_drain = 0;
                end else if (cyc && stb && !s_ack && !s_err) m_age = m_age + 1;
                else m_age = 0;
            end
        end
    end

    always @(negedge wb_clk) begin
        bit ab, fwd;
        if (wb_rst) m_reset();
        ab  = m_aborting();
        fwd = !ab && !m_drain;
        chk("adr_pass", wbm_adr_o, adr);
        chk("dat_pass", wbm_dat_o, dat_w);
        chk("sel_pass", {28'd0, wbm_sel_o}, {28'd0, sel});
        chk("we_pass", {31'd0, wbm_we_o}, {31'd0, we});
        chk("wbm_cyc", {31'd0, wbm_cyc_o}, {31'd0, fwd & cyc});
        chk("wbm_stb", {31'd0, wbm_stb_o}, {31'd0, fwd & stb});
        chk("wbs_ack", {31'd0, wbs_ack_o}, {31'd0, ab | (fwd & s_ack)});
        chk("wbs_err", {31'd0, wbs_err_o}, {31'd0, ab | (fwd & s_err)});
        chk("timeout", {31'd0, timeout_o}, {31'd0, ab});
        if (ab) chk("abort_dat", wbs_dat_o, POISON);
        else if (fwd && s_ack) chk("read_dat", wbs_dat_o, s_dat);
        chk("fault_adr", fault_adr_o, m_fadr);
        chk("fault_we", {31'd0, fault_we_o}, {31'd0, m_fwe});
        chk("fault_cnt", {24'd0, fault_cnt_o}, 32'(m_fcnt));
    end

    task automatic step();
        @(posedge wb_clk); #1;
    endtask

    task automatic xfer(input logic [31:0] a, input logic w, input int ack_at, input logic [31:0] rd,
                        input bit hold, input int clr_at,
                        output int done, output logic to, output logic [31:0] got, output logic cyc_done);
        cyc = 1'b1; stb = 1'b1; adr = a; we = w; dat_w = a ^ 32'h5A5A_5A5A;
        done = -1; to = 1'b0; got = '0; cyc_done = 1'b0;
        for (int k = 0; k < TO + 4 && done < 0; k++) begin
            s_ack = (k == ack_at);
            s_dat = (k == ack_at) ? rd : 32'h0;
            clr   = (k == clr_at);
            @(negedge wb_clk);
            if (wbs_ack_o) begin
                done = k; to = timeout_o; got = wbs_dat_o; cyc_done = wbm_cyc_o;
            end
            step();
        end
        s_ack = 1'b0; s_dat = '0; clr = 1'b0;
        if (!hold) begin
            cyc = 1'b0; stb = 1'b0;
            step();
        end
    endtask

    initial begin
        int d; logic t; logic [31:0] g; logic c;
        repeat (2) step();
        chk("rst_fault_cnt", {24'd0, fault_cnt_o}, 32'd0);
        chk("rst_fault_adr", fault_adr_o, 32'd0);
        chk("rst_timeout", {31'd0, timeout_o}, 32'd0);
        wb_rst = 1'b0;
        step();

        xfer(32'h1000_0000, 1'b0, 3, 32'h1234_5678, 0, -1, d, t, g, c);
        chk("rd_done_cyc", 32'(d), 32'd3);
        chk("rd_no_to", {31'd0, t}, 32'd0);
        chk("rd_data", g, 32'h1234_5678);
        chk("rd_fcnt", {24'd0, fault_cnt_o}, 32'd0);

        xfer(32'h9000_0000, 1'b1, -1, '0, 0, -1, d, t, g, c);
        chk("to_done_cyc", 32'(d), 32'd16);
        chk("to_flag", {31'd0, t}, 32'd1);
        chk("to_data", g, POISON);
        chk("to_cyc_dropped", {31'd0, c}, 32'd0);
        chk("to_fadr", fault_adr_o, 32'h9000_0000);
        chk("to_fwe", {31'd0, fault_we_o}, 32'd1);
        chk("to_fcnt", {24'd0, fault_cnt_o}, 32'd1);

        xfer(32'h2000_0040, 1'b0, 15, 32'hCAFE_0015, 0, -1, d, t, g, c);
        chk("late_ok_cyc", 32'(d), 32'd15);
        chk("late_ok_no_to", {31'd0, t}, 32'd0);

        // Aborted transfer with stb held into DRAIN and the slave acking late.
        xfer(32'h3000_0000, 1'b0, 16, 32'h1111_1111, 1, -1, d, t, g, c);
        chk("drain_abort_cyc", 32'(d), 32'd16);
        s_ack = 1'b1; s_dat = 32'h2222_2222;
        @(negedge wb_clk);
        chk("drain_no_ack", {31'd0, wbs_ack_o}, 32'd0);
        chk("drain_no_stb", {31'd0, wbm_stb_o}, 32'd0);
        step();
        s_ack = 1'b0; cyc = 1'b0; stb = 1'b0;
        step();
        chk("drain_fcnt", {24'd0, fault_cnt_o}, 32'd2);

        for (int i = 0; i < 5; i++) begin
            xfer(32'h1000_0100 + 32'(i * 4), 1'b0, 10, 32'hA000_0000 + 32'(i), 1, -1, d, t, g, c);
            chk("b2b_cyc", 32'(d), 32'd10);
            chk("b2b_data", g, 32'hA000_0000 + 32'(i));
        end
        cyc = 1'b0; stb = 1'b0;
        step();
        chk("b2b_fcnt", {24'd0, fault_cnt_o}, 32'd2);

        s_err = 1'b1; cyc = 1'b1; stb = 1'b1; adr = 32'h4000_0000;
        @(negedge wb_clk);
        chk("err_fwd", {31'd0, wbs_err_o}, 32'd1);
        step();
        s_err = 1'b0; cyc = 1'b0; stb = 1'b0;
        step();

        clr = 1'b1; step(); clr = 1'b0;
        chk("clr_fcnt", {24'd0, fault_cnt_o}, 32'd0);
        for (int i = 0; i < 300; i++) xfer(32'h9000_0000 + 32'(i), 1'b0, -1, '0, 0, -1, d, t, g, c);
        chk("sat_fcnt", {24'd0, fault_cnt_o}, 32'd255);
        xfer(32'h9100_0000, 1'b0, -1, '0, 0, 16, d, t, g, c);
        chk("clr_abort_fcnt", {24'd0, fault_cnt_o}, 32'd1);

        cyc = 1'b1; stb = 1'b1; adr = 32'h5000_0000; we = 1'b1;
        repeat (8) step();
        wb_rst = 1'b1; #1;
        chk("mid_rst_fcnt", {24'd0, fault_cnt_o}, 32'd0);
        chk("mid_rst_fadr", fault_adr_o, 32'd0);
        chk("mid_rst_fwe", {31'd0, fault_we_o}, 32'd0);
        chk("mid_rst_cyc_follow", {31'd0, wbm_cyc_o}, 32'd1);
        step();
        wb_rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        step();
        xfer(32'h6000_0000, 1'b0, -1, '0, 0, -1, d, t, g, c);
        chk("post_rst_to_cyc", 32'(d), 32'd16);
        chk("post_rst_to_flag", {31'd0, t}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
